// File: rtl/gate_actuator.sv
// Parking gate actuator: drives the gate motor between closed and open,
// auto-closes after a hold time, reverses on obstruction while closing and
// locks out after repeated obstruction reversals until cleared.
module gate_actuator #(
    parameter int TRAVEL  = 8,
    parameter int HOLD    = 16,
    parameter int MAX_REV = 3
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          open,
    input  logic                          close,
    input  logic                          obst,
    output logic                          motor_up,
    output logic                          motor_dn,
    output logic                          is_open,
    output logic                          is_closed,
    output logic                          fault,
    output logic [$clog2(TRAVEL+1)-1:0]   pos
);

    localparam int PW = $clog2(TRAVEL + 1);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int RW = $clog2(MAX_REV + 1);

    localparam logic [2:0] ST_CLOSED  = 3'd0;
    localparam logic [2:0] ST_OPENING = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_CLOSING = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;

    localparam logic [PW-1:0] POS_MAX   = PW'(TRAVEL);
    localparam logic [PW-1:0] POS_ONE   = PW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [RW-1:0] REV_LIMIT = RW'(MAX_REV);

    logic [2:0]    state_r;
    logic [2:0]    state_nx_s;
    logic [PW-1:0] pos_nx_s;
    logic [HW-1:0] hold_r;
    logic [HW-1:0] hold_nx_s;
    logic [RW-1:0] rev_r;
    logic [RW-1:0] rev_nx_s;

    // Next-state, position, hold-timer and reversal-count computation.
    always_comb begin
        state_nx_s = state_r;
        pos_nx_s   = pos;
        hold_nx_s  = hold_r;
        rev_nx_s   = rev_r;
        case (state_r)
            ST_CLOSED: begin
                if (open) begin
                    state_nx_s = ST_OPENING;
                end else begin
                    state_nx_s = ST_CLOSED;
                end
            end
            ST_OPENING: begin
                // '>=' also covers a reversal that started at full travel,
                // so pos can never run past TRAVEL.
                if (pos >= (POS_MAX - POS_ONE)) begin
                    state_nx_s = ST_OPEN;
                    pos_nx_s   = POS_MAX;
                    hold_nx_s  = {HW{1'b0}};
                end else begin
                    pos_nx_s   = pos + POS_ONE;
                end
            end
            ST_OPEN: begin
                if (open) begin
                    hold_nx_s  = {HW{1'b0}};
                end else if (obst) begin
                    hold_nx_s  = hold_r;
                end else if (close || (hold_r >= HOLD_LAST)) begin
                    state_nx_s = ST_CLOSING;
                end else begin
                    hold_nx_s  = hold_r + HW'(1);
                end
            end
            ST_CLOSING: begin
                if (open) begin
                    // Operator-requested reversal is not an obstruction event.
                    state_nx_s = ST_OPENING;
                    rev_nx_s   = {RW{1'b0}};
                end else if (obst) begin
                    rev_nx_s = rev_r + RW'(1);
                    if ((rev_r + RW'(1)) >= REV_LIMIT) begin
                        state_nx_s = ST_FAULT;
                    end else begin
                        state_nx_s = ST_OPENING;
                    end
                end else if (pos <= POS_ONE) begin
                    state_nx_s = ST_CLOSED;
                    pos_nx_s   = {PW{1'b0}};
                    rev_nx_s   = {RW{1'b0}};
                end else begin
                    pos_nx_s   = pos - POS_ONE;
                end
            end
            ST_FAULT: begin
                state_nx_s = ST_FAULT;
            end
            default: begin
                state_nx_s = ST_CLOSED;
                pos_nx_s   = {PW{1'b0}};
                hold_nx_s  = {HW{1'b0}};
                rev_nx_s   = {RW{1'b0}};
            end
        endcase
    end

    // State, counters and Moore outputs registered together; clr overrides all.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r   <= ST_CLOSED;
            pos       <= {PW{1'b0}};
            hold_r    <= {HW{1'b0}};
            rev_r     <= {RW{1'b0}};
            motor_up  <= 1'b0;
            motor_dn  <= 1'b0;
            is_open   <= 1'b0;
            is_closed <= 1'b1;
            fault     <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            pos       <= pos_nx_s;
            hold_r    <= hold_nx_s;
            rev_r     <= rev_nx_s;
            motor_up  <= (state_nx_s == ST_OPENING);
            motor_dn  <= (state_nx_s == ST_CLOSING);
            is_open   <= (state_nx_s == ST_OPEN);
            is_closed <= (state_nx_s == ST_CLOSED);
            fault     <= (state_nx_s == ST_FAULT);
        end
    end

endmodule
